// File: rtl/trigger_pkg.sv
// Shared types and helpers for the trigger batcher and its popcount tree.
package trigger_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } trigger_state_e;

  // Widest source vector the popcount helper accepts; callers zero-extend.
  localparam int unsigned POP_MAX = 64;

  // Width needed to hold a count of 0..n triggers.
  function automatic int unsigned inc_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Number of set bits in a (zero-extended) source vector.
  function automatic int unsigned popcount(input logic [POP_MAX-1:0] bits);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      c += int'(bits[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Purely combinational count of asserted source requests.
module popcount_tree
  import trigger_pkg::*;
#(
  parameter int N_SRC = 4,
  localparam int CW = inc_width(N_SRC)
) (
  input  logic [N_SRC-1:0] bits,
  output logic [CW-1:0]    count
);

  // Zero-extend into the helper's fixed width and narrow the result back down.
  always_comb begin
    count = CW'(popcount(POP_MAX'(bits)));
  end

endmodule

// File: rtl/trigger_batcher.sv
// Collects per-source trigger requests into a backlog and hands them
// downstream as a clamped delta whenever the receiver is ready.
module trigger_batcher
  import trigger_pkg::*;
#(
  parameter int N_SRC         = 4,
  parameter int WIDTH         = 8,
  parameter int BACKLOG_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_SRC-1:0]         src_valid,
  output logic                     src_ready,
  output logic [WIDTH-1:0]         delta,
  input  logic                     delta_ready,
  output logic [BACKLOG_WIDTH-1:0] backlog
);

  localparam int IW     = inc_width(N_SRC);
  localparam int BMAX   = (2 ** BACKLOG_WIDTH) - 1;
  localparam int WMAX   = (2 ** WIDTH) - 1;
  localparam int DMAX   = (WMAX < BMAX) ? WMAX : BMAX;
  localparam int THRESH = BMAX - N_SRC;

  localparam logic [BACKLOG_WIDTH-1:0] THRESH_V = BACKLOG_WIDTH'(THRESH);
  localparam logic [BACKLOG_WIDTH-1:0] DMAX_V   = BACKLOG_WIDTH'(DMAX);

  trigger_state_e             state_q;
  trigger_state_e             state_d;
  logic [BACKLOG_WIDTH-1:0]   backlog_q;
  logic [BACKLOG_WIDTH:0]     backlog_next;
  logic [BACKLOG_WIDTH-1:0]   emit;
  logic [IW-1:0]              pop;
  logic [IW-1:0]              inc;

  popcount_tree #(
    .N_SRC (N_SRC)
  ) u_popcount (
    .bits  (src_valid),
    .count (pop)
  );

  assign backlog = backlog_q;

  // Register-driven outputs and the combined accept/emit backlog update.
  always_comb begin
    src_ready = (backlog_q <= THRESH_V);
    inc       = src_ready ? pop : '0;
    emit      = '0;
    if (delta_ready && (state_q != IDLE)) begin
      emit = (backlog_q > DMAX_V) ? DMAX_V : backlog_q;
    end
    delta        = WIDTH'(emit);
    backlog_next = {1'b0, backlog_q} - {1'b0, emit} + (BACKLOG_WIDTH + 1)'(inc);
  end

  // Next-state selection; the state always tracks where the backlog lands.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (inc != '0) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (backlog_next == '0)                         state_d = IDLE;
        else if (backlog_next > {1'b0, THRESH_V})       state_d = FULL;
      end
      FULL: begin
        if (backlog_next == '0)                         state_d = IDLE;
        else if (backlog_next <= {1'b0, THRESH_V})      state_d = ACTIVE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and backlog registers; reset discards any pending triggers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      backlog_q <= '0;
    end else begin
      state_q   <= state_d;
      backlog_q <= backlog_next[BACKLOG_WIDTH-1:0];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !backlog_next[BACKLOG_WIDTH]);

  a_state_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    ((state_q == IDLE) == (backlog_q == '0)) &&
    ((state_q == FULL) == (backlog_q > THRESH_V)));

  a_delta_gated: assert property (@(posedge clk) disable iff (!rst_n)
    !delta_ready |-> (delta == '0));

endmodule

// File: tb/tb_trigger_batcher.sv
// Directed bench: default-sized batcher plus a narrow instance for
// saturation and delta clamping.
module tb_trigger_batcher;
  import trigger_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] src_valid;
  logic       src_ready;
  logic [7:0] delta;
  logic       delta_ready;
  logic [7:0] backlog;

  logic [3:0] s_src_valid;
  logic       s_src_ready;
  logic [2:0] s_delta;
  logic       s_delta_ready;
  logic [3:0] s_backlog;

  int checkCount = 0;
  int errorCount = 0;
  int total;

  trigger_batcher #(
    .N_SRC(4), .WIDTH(8), .BACKLOG_WIDTH(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .delta       (delta),
    .delta_ready (delta_ready),
    .backlog     (backlog)
  );

  trigger_batcher #(
    .N_SRC(4), .WIDTH(3), .BACKLOG_WIDTH(4)
  ) dut_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_valid   (s_src_valid),
    .src_ready   (s_src_ready),
    .delta       (s_delta),
    .delta_ready (s_delta_ready),
    .backlog     (s_backlog)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic ready);
    src_valid   = valid;
    delta_ready = ready;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    src_valid     = '0;
    delta_ready   = 1'bx;
    s_src_valid   = '0;
    s_delta_ready = 1'b0;
    #12;
    checkOutput("reset backlog", int'(backlog), 0);
    checkOutput("reset delta x ready", int'(delta), 0);
    checkOutput("reset src_ready", int'(src_ready), 1);
    checkOutput("reset state", int'(dut.state_q), int'(IDLE));
    rst_n = 1'b1;

    // Single trigger
    applyStimulus(4'b0001, 1'b1);
    checkOutput("single no bypass", int'(delta), 0);
    tick();
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single backlog t+1", int'(backlog), 1);
    checkOutput("single delta t+1", int'(delta), 1);
    checkOutput("single state t+1", int'(dut.state_q), int'(ACTIVE));
    tick();
    checkOutput("single backlog t+2", int'(backlog), 0);
    checkOutput("single state t+2", int'(dut.state_q), int'(IDLE));

    // Burst with simultaneous accept and emit
    applyStimulus(4'b1111, 1'b1);
    total = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) applyStimulus(4'b0000, 1'b1);
      checkOutput($sformatf("burst delta %0d", i), int'(delta), 4);
      total += int'(delta);
    end
    tick();
    checkOutput("burst drained", int'(backlog), 0);
    checkOutput("burst total", total, 12);

    // Stall
    applyStimulus(4'b1111, 1'b0);
    checkOutput("stall delta 0", int'(delta), 0);
    tick();
    checkOutput("stall delta 1", int'(delta), 0);
    checkOutput("stall backlog 1", int'(backlog), 4);
    tick();
    applyStimulus(4'b0000, 1'b0);
    checkOutput("stall backlog 2", int'(backlog), 8);
    checkOutput("stall delta 2", int'(delta), 0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("stall release delta", int'(delta), 8);
    tick();
    checkOutput("stall drained", int'(backlog), 0);
    checkOutput("stall drained delta", int'(delta), 0);

    // Reset mid-operation
    applyStimulus(4'b1111, 1'b0);
    tick();
    applyStimulus(4'b0011, 1'b0);
    tick();
    applyStimulus(4'b0000, 1'b1);
    checkOutput("mid backlog", int'(backlog), 6);
    checkOutput("mid delta", int'(delta), 6);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset backlog", int'(backlog), 0);
    checkOutput("async reset delta", int'(delta), 0);
    checkOutput("async reset src_ready", int'(src_ready), 1);
    checkOutput("async reset state", int'(dut.state_q), int'(IDLE));
    #1;
    rst_n = 1'b1;
    applyStimulus(4'b0001, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b1);
    checkOutput("post reset backlog", int'(backlog), 1);
    checkOutput("post reset delta", int'(delta), 1);
    tick();
    checkOutput("post reset drained", int'(backlog), 0);

    // Saturation on the narrow instance (threshold 11)
    s_src_valid   = 4'b1111;
    s_delta_ready = 1'b0;
    #1;
    checkOutput("sat ready start", int'(s_src_ready), 1);
    tick();
    checkOutput("sat backlog 4", int'(s_backlog), 4);
    tick();
    checkOutput("sat backlog 8", int'(s_backlog), 8);
    checkOutput("sat ready at 8", int'(s_src_ready), 1);
    tick();
    checkOutput("sat backlog 12", int'(s_backlog), 12);
    checkOutput("sat ready drop", int'(s_src_ready), 0);
    checkOutput("sat state full", int'(dut_small.state_q), int'(FULL));
    tick();
    checkOutput("sat backlog held", int'(s_backlog), 12);
    checkOutput("sat delta stalled", int'(s_delta), 0);

    // Clamp and drain
    s_src_valid   = 4'b0000;
    s_delta_ready = 1'b1;
    #1;
    checkOutput("clamp delta 7", int'(s_delta), 7);
    tick();
    checkOutput("clamp backlog 5", int'(s_backlog), 5);
    checkOutput("clamp delta 5", int'(s_delta), 5);
    checkOutput("clamp ready rise", int'(s_src_ready), 1);
    tick();
    checkOutput("clamp backlog 0", int'(s_backlog), 0);
    checkOutput("clamp delta 0", int'(s_delta), 0);
    checkOutput("clamp state idle", int'(dut_small.state_q), int'(IDLE));

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/trigger_batcher.md
# trigger_batcher

Transmit-side companion to the trigger counter. Collects one-bit trigger requests from `N_SRC` caller sources, counts how many fire each cycle, and holds them in a local backlog. It then drives the counter's `delta`/`delta_ready` interface, never issuing a non-zero delta unless the counter reports ready. It sits between the callers of a module and that module's trigger counter, and absorbs multi-caller bursts and downstream stalls.

## Interface
- `N_SRC`, 4: number of caller sources; must be ≥ 1.
- `WIDTH`, 8: width of `delta`; matches the downstream counter's `WIDTH`.
- `BACKLOG_WIDTH`, 8: width of the internal backlog register; must satisfy 2^BACKLOG_WIDTH − 1 ≥ 2·N_SRC.
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `src_valid`  in  N_SRC  per-source trigger request for this cycle.
- `src_ready`  out  1  shared acceptance; triggers count only when this is 1.
- `delta`  out  WIDTH  number of triggers handed downstream this cycle.
- `delta_ready`  in  1  downstream can accept a non-zero delta this cycle.
- `backlog`  out  BACKLOG_WIDTH  current pending-trigger count (observability).

## Operation
Definitions:
- `BMAX` = 2^BACKLOG_WIDTH − 1.
- `DMAX` = min(2^WIDTH − 1, BMAX).
- `inc` = popcount(`src_valid`) if `src_ready`, else 0. `inc` is clog2(N_SRC+1) bits wide.

Combinational outputs, driven from registers only (no `src_valid`-to-`delta` path):
- `delta` = (`delta_ready` && state ≠ IDLE) ? min(`backlog`, DMAX) : 0.
- `src_ready` = (`backlog` ≤ BMAX − N_SRC).

Backlog update:
- `backlog_next` = `backlog` − `delta` + `inc`.
- Computed at BACKLOG_WIDTH+1 bits. Overflow is impossible by construction; an assertion checks that bit BACKLOG_WIDTH is never set.

FSM, state register reset to IDLE:
- IDLE: `backlog` == 0.
  - Go to ACTIVE if `inc` > 0.
- ACTIVE: `backlog` > 0 and `src_ready` = 1.
  - Go to IDLE if `backlog_next` == 0.
  - Go to FULL if `backlog_next` > BMAX − N_SRC.
- FULL: `src_ready` = 0. All source requests are dropped, not queued; callers must hold `src_valid` until they see `src_ready`.
  - Go to ACTIVE once `backlog_next` ≤ BMAX − N_SRC.
  - Go directly to IDLE if `backlog_next` == 0.
- The state is always consistent with `backlog_next`. A mismatch is an assertion failure.

## Timing
Reset values: `backlog` = 0, state = IDLE, `delta` = 0, `src_ready` = 1.

Latency:
- A trigger accepted in cycle t appears in `backlog` at t+1.
- With `delta_ready` high, it is emitted on `delta` in cycle t+1, so minimum latency is 1 cycle.
- There is no same-cycle bypass.

Handshakes:
- `delta` is consumed by the receiver every cycle. `delta` must therefore be 0 whenever `delta_ready` = 0.
- A `delta_ready` that is X or 0 after reset gives `delta` = 0.

Boundary conditions:
- Simultaneous accept and emit: the emitted backlog and the newly accepted `inc` combine in one update. Nothing is lost or double-counted.
- Backlog > DMAX: emit DMAX per cycle until drained.
- Reset asserted mid-burst: the backlog is discarded and the block returns to IDLE asynchronously. Pending triggers are lost by design.

## Structure
- Shared package `trigger_pkg`:
  - `trigger_state_e` enum (IDLE, ACTIVE, FULL).
  - `popcount` function, parameterised by width.
  - clog2 helper constant for the `inc` width.
- One sub-module: `popcount_tree` (N_SRC in, clog2(N_SRC+1) out, purely combinational).
- The top level holds the backlog register, FSM, clamp logic and assertions.

## Test plan
- Single trigger: after reset, `src_valid`=0001 for one cycle with `delta_ready`=1 → `backlog`=1 and `delta`=1 at t+1; `backlog`=0 and IDLE at t+2.
- Burst: `src_valid`=1111 for 3 cycles with `delta_ready`=1 → `delta` = 4, 4, 4 on cycles t+1..t+3; total 12 emitted.
- Stall: `delta_ready`=0 while `src_valid`=1111 for 2 cycles → `delta`=0 throughout, `backlog`=8. Raising `delta_ready` → `delta`=8 for one cycle, then `backlog`=0.
- Saturation: BACKLOG_WIDTH=4, N_SRC=4, `delta_ready`=0, `src_valid`=1111 held → `backlog` reaches 12; `src_ready` drops once `backlog` > 11; `backlog` never exceeds 15. Releasing `delta_ready` drains to 0 and `src_ready` rises.
- Clamp: WIDTH=3 with `backlog`=12 and `delta_ready`=1 → `delta` = 7, then 5, then 0.
- Reset mid-operation: with `backlog`=6, pulse `rst_n` low between clock edges → `backlog`=0, `delta`=0, `src_ready`=1 immediately. A subsequent trigger behaves as in the first scenario.
